fetch_gshare: RTL

- Parametrised next-generation instruction fetch unit.
- Issues sequential PCs to a synchronous instruction memory and predecodes returned words.
- Predicts conditional branches with a gshare pattern history table and always takes JAL.
- Buffers fetched instructions in a FIFO with a valid/ready handshake toward decode/issue. Commit-time redirects flush all fetch state and restart from the corrected PC.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/gshare_pht.sv | 39 +++
 rtl/fetch_gshare.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch definitions: opcodes, queue entry layout and immediate decoders.
package fetch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fq_entry_t;

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// gshare direction predictor: 2-bit counters indexed by pc ^ global history.
module gshare_pht #(
    parameter int HIST_BITS = 10
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [HIST_BITS+1:2]   rd_pc_i,
    output logic                   taken_o,
    input  logic                   upd_i,
    input  logic                   upd_taken_i,
    input  logic [HIST_BITS+1:2]   upd_pc_i
);

    localparam int N = 1 << HIST_BITS;

    logic [1:0]           cnt_q [N];
    logic [HIST_BITS-1:0] hist_q;
    logic [HIST_BITS-1:0] rd_idx, wr_idx;

    assign rd_idx  = rd_pc_i ^ hist_q;
    assign wr_idx  = upd_pc_i ^ hist_q;
    // Combinational read of the registered table: a same-cycle update is not visible.
    assign taken_o = cnt_q[rd_idx][1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= 2'b01;
            hist_q <= '0;
        end else if (upd_i) begin
            if (upd_taken_i) begin
                if (cnt_q[wr_idx] != 2'b11) cnt_q[wr_idx] <= cnt_q[wr_idx] + 2'd1;
            end else begin
                if (cnt_q[wr_idx] != 2'b00) cnt_q[wr_idx] <= cnt_q[wr_idx] - 2'd1;
            end
            hist_q <= {hist_q[HIST_BITS-2:0], upd_taken_i};
        end
    end

endmodule

// File: rtl/fetch_gshare.sv
// Two-stage fetch unit with predecode, branch prediction and an output queue.
// FETCH_STATIC_BTFN_EN replaces gshare with backward-taken/forward-not-taken.
module fetch_gshare
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          HIST_BITS = 10,
    parameter int          FQ_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        bp_update,
    input  logic        bp_taken,
    input  logic [31:0] bp_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_pred_taken,
    output logic [31:0] out_pred_target
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);

    logic [31:0]   pc_q, pc_d, f2_pc_q;
    logic          f2_vld_q, f2_vld_d, f2_taken;
    fq_entry_t     fq_q [FQ_DEPTH];
    fq_entry_t     f2_ent;
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] cnt_q;
    logic          push, pop, br_taken;
    logic [31:0]   immb, immj;

    assign immb = imm_b(imem_rdata);
    assign immj = imm_j(imem_rdata);

`ifdef FETCH_STATIC_BTFN_EN
    assign br_taken = immb[31];
    logic unused_bp;
    assign unused_bp = ^{bp_update, bp_taken, bp_pc};
`else
    gshare_pht #(.HIST_BITS(HIST_BITS)) u_pht (
        .clk_i       (clk),
        .reset_i     (reset),
        .rd_pc_i     (f2_pc_q[HIST_BITS+1:2]),
        .taken_o     (br_taken),
        .upd_i       (bp_update),
        .upd_taken_i (bp_taken),
        .upd_pc_i    (bp_pc[HIST_BITS+1:2])
    );
    logic unused_bp;
    assign unused_bp = ^{bp_pc[31:HIST_BITS+2], bp_pc[1:0]};
`endif

    always_comb begin
        f2_ent.pc          = f2_pc_q;
        f2_ent.instr       = imem_rdata;
        f2_ent.pred_taken  = 1'b0;
        f2_ent.pred_target = f2_pc_q + 32'd4;
        if (imem_rdata[6:0] == OP_BRANCH && br_taken) begin
            f2_ent.pred_taken  = 1'b1;
            f2_ent.pred_target = f2_pc_q + immb;
        end else if (imem_rdata[6:0] == OP_JAL) begin
            f2_ent.pred_taken  = 1'b1;
            f2_ent.pred_target = f2_pc_q + immj;
        end
    end

    // Credit check counts the in-flight F2 word so a push always has a slot.
    assign imem_req  = !reset && !redirect
                     && (32'(cnt_q) + 32'(f2_vld_q)) < 32'(FQ_DEPTH);
    assign imem_addr = pc_q;
    assign f2_taken  = f2_vld_q && f2_ent.pred_taken;

    always_comb begin
        pc_d     = pc_q;
        f2_vld_d = imem_req && !f2_taken;
        if (redirect)      pc_d = redirect_pc;
        else if (f2_taken) pc_d = f2_ent.pred_target;
        else if (imem_req) pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            f2_vld_q <= 1'b0;
            f2_pc_q  <= RESET_PC;
        end else begin
            pc_q     <= pc_d;
            f2_vld_q <= f2_vld_d;
            f2_pc_q  <= pc_q;
        end
    end

    assign out_valid = (cnt_q != '0);
    assign push      = f2_vld_q && !redirect;
    assign pop       = out_valid && out_ready && !redirect;

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fq_q[tail_q] <= f2_ent;
    end

    assign out_pc          = fq_q[head_q].pc;
    assign out_instr       = fq_q[head_q].instr;
    assign out_pred_taken  = fq_q[head_q].pred_taken;
    assign out_pred_target = fq_q[head_q].pred_target;

endmodule
